// File: rtl/ddf_pkg.sv
// Shared types and helpers for the ddf reducer/expander actor family.
package ddf_pkg;

    typedef enum logic {
        PICK = 1'b0,
        EMIT = 1'b1
    } ddf_state_e;

    // Tag width is never allowed to collapse to zero bits.
    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int unsigned tok_width(input int unsigned data_w, input int unsigned flux);
        return data_w + tag_width(flux);
    endfunction

    // Flat position of port p of flux f in the per-port FIFO vectors.
    function automatic int unsigned idx(input int unsigned p, input int unsigned f,
                                        input int unsigned ports);
        return p + f * ports;
    endfunction

endpackage

// File: rtl/ddf_prio_arb.sv
// Fixed-priority picker: the lowest eligible index wins, reported one-hot and binary.
module ddf_prio_arb
    import ddf_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned TW = tag_width(N)
) (
    input  logic [N-1:0]  elig_i,
    output logic [N-1:0]  grant_o,
    output logic [TW-1:0] tag_o,
    output logic          valid_o
);

    always_comb begin
        grant_o = '0;
        tag_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig_i[i] && !valid_o) begin
                grant_o[i] = 1'b1;
                tag_o      = TW'(i);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddf_expand.sv
// Multi-flux expander: re-emits each tagged token N times on all ports of its flux.
// Optional build macro DDF_EXPAND_BYPASS_EN writes the first copy in the pick cycle.
module ddf_expand
    import ddf_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FLUX       = 2,
    parameter  int unsigned PORTS      = 2,
    localparam int unsigned TAG_WIDTH  = tag_width(FLUX),
    localparam int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       rd_dout_i,
    input  logic                   rd_empty_i,
    output logic                   rd_read_o,
    input  logic [WIDTH-1:0]       nda_dout_i,
    input  logic [FLUX-1:0]        nda_empty_i,
    output logic [FLUX-1:0]        nda_read_o,
    output logic [WIDTH*PORTS-1:0] wr_din_o,
    input  logic [PORTS*FLUX-1:0]  wr_full_i,
    output logic [PORTS*FLUX-1:0]  wr_write_o
);

    ddf_state_e            state_q [FLUX];
    ddf_state_e            state_d [FLUX];
    logic [DATA_WIDTH-1:0] cnt_q   [FLUX];
    logic [DATA_WIDTH-1:0] cnt_d   [FLUX];
    logic [DATA_WIDTH-1:0] hold_q  [FLUX];
    logic [DATA_WIDTH-1:0] hold_d  [FLUX];

    logic [TAG_WIDTH-1:0]  head_tag;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] n_adj;
    logic                  head_bad;
    logic                  nda_hi_unused;
    logic [FLUX-1:0]       port_free;
    logic [FLUX-1:0]       elig;
    logic [FLUX-1:0]       grant;
    logic [TAG_WIDTH-1:0]  win_tag;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] din_val;

    assign head_tag      = rd_dout_i[WIDTH-1 -: TAG_WIDTH];
    assign head_data     = rd_dout_i[DATA_WIDTH-1:0];
    assign head_bad      = 32'(head_tag) >= FLUX;
    assign nda_hi_unused = ^nda_dout_i[WIDTH-1:DATA_WIDTH];
    // A zero repeat count still produces one copy.
    assign n_adj = (nda_dout_i[DATA_WIDTH-1:0] == '0) ? DATA_WIDTH'(1)
                                                       : nda_dout_i[DATA_WIDTH-1:0];

    always_comb begin
        port_free = '0;
        elig      = '0;
        for (int f = 0; f < FLUX; f++) begin
            port_free[f] = ~|wr_full_i[idx(0, f, PORTS) +: PORTS];
            if (state_q[f] == PICK)
                elig[f] = !rd_empty_i && (head_tag == TAG_WIDTH'(f)) && !nda_empty_i[f];
            else
                elig[f] = port_free[f];
        end
    end

    ddf_prio_arb #(
        .N (FLUX)
    ) u_arb (
        .elig_i  (elig),
        .grant_o (grant),
        .tag_o   (win_tag),
        .valid_o (win_valid)
    );

    // Service the single winning flux; everything else holds.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        rd_read_o  = 1'b0;
        nda_read_o = '0;
        wr_write_o = '0;
        din_val    = hold_q[0];
        for (int f = 0; f < FLUX; f++) begin
            if (win_tag == TAG_WIDTH'(f))
                din_val = hold_q[f];
        end
        for (int f = 0; f < FLUX; f++) begin
            if (grant[f]) begin
                if (state_q[f] == PICK) begin
                    rd_read_o     = 1'b1;
                    nda_read_o[f] = 1'b1;
                    hold_d[f]     = head_data;
`ifdef DDF_EXPAND_BYPASS_EN
                    if (port_free[f]) begin
                        wr_write_o[idx(0, f, PORTS) +: PORTS] = '1;
                        din_val    = head_data;
                        cnt_d[f]   = n_adj - DATA_WIDTH'(1);
                        state_d[f] = (n_adj == DATA_WIDTH'(1)) ? PICK : EMIT;
                    end else begin
                        cnt_d[f]   = n_adj;
                        state_d[f] = EMIT;
                    end
`else
                    cnt_d[f]   = n_adj;
                    state_d[f] = EMIT;
`endif
                end else begin
                    wr_write_o[idx(0, f, PORTS) +: PORTS] = '1;
                    cnt_d[f] = cnt_q[f] - DATA_WIDTH'(1);
                    if (cnt_q[f] == DATA_WIDTH'(1))
                        state_d[f] = PICK;
                end
            end
        end
        // Out-of-range tags are discarded only when nobody else wants the cycle.
        if (!win_valid && !rd_empty_i && head_bad)
            rd_read_o = 1'b1;
        if (rst) begin
            rd_read_o  = 1'b0;
            nda_read_o = '0;
            wr_write_o = '0;
        end
    end

    assign wr_din_o = {PORTS{win_tag, din_val}};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= PICK;
                cnt_q[f]   <= '0;
                hold_q[f]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_ddf_expand.sv
// Directed bench for ddf_expand at DATA_WIDTH=8, FLUX=2, PORTS=2.
module tb_ddf_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  rd_dout;
    logic        rd_empty;
    logic        rd_read;
    logic [8:0]  nda_dout;
    logic [1:0]  nda_empty;
    logic [1:0]  nda_read;
    logic [17:0] wr_din;
    logic [3:0]  wr_full;
    logic [3:0]  wr_write;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddf_expand #(
        .DATA_WIDTH (8),
        .FLUX       (2),
        .PORTS      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_dout_i  (rd_dout),
        .rd_empty_i (rd_empty),
        .rd_read_o  (rd_read),
        .nda_dout_i (nda_dout),
        .nda_empty_i(nda_empty),
        .nda_read_o (nda_read),
        .wr_din_o   (wr_din),
        .wr_full_i  (wr_full),
        .wr_write_o (wr_write)
    );

    typedef struct {
        logic       r;
        logic       re;
        logic [8:0] rd;
        logic [1:0] ne;
        logic [7:0] n;
        logic [3:0] fu;
        logic       rr;
        logic [1:0] nr;
        logic [3:0] wr;
        logic [8:0] din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic re, input logic [8:0] rd,
                                input logic [1:0] ne, input logic [7:0] n, input logic [3:0] fu,
                                input logic rr, input logic [1:0] nr, input logic [3:0] wr,
                                input logic [8:0] din);
        vec_t v;
        v.r = r; v.re = re; v.rd = rd; v.ne = ne; v.n = n; v.fu = fu;
        v.rr = rr; v.nr = nr; v.wr = wr; v.din = din;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v, input int row);
        @(negedge clk);
        rst       = v.r;
        rd_empty  = v.re;
        rd_dout   = v.rd;
        nda_empty = v.ne;
        nda_dout  = {1'b0, v.n};
        wr_full   = v.fu;
        #2;
        check("rd_read", row, 32'(rd_read), 32'(v.rr));
        check("nda_read", row, 32'(nda_read), 32'(v.nr));
        check("write", row, 32'(wr_write), 32'(v.wr));
        check("din", row, 32'(wr_din), 32'({v.din, v.din}));
    endtask

    initial begin
        int nw;
        int first;
        int last;
        rst = 1'b1; rd_empty = 1'b1; rd_dout = '0;
        nda_empty = 2'b11; nda_dout = '0; wr_full = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("idle", i, 32'({rd_read, nda_read, wr_write}), 32'h0);
            @(negedge clk);
        end

        // Reset asserted with live inputs must suppress every strobe.
        tbl.push_back(mk(1, 0, 9'h02A, 2'b00, 8'd3, 4'h0, 0, 2'b00, 4'h0, 9'h000));
`ifndef DDF_EXPAND_BYPASS_EN
        tbl.push_back(mk(0, 0, 9'h02A, 2'b00, 8'd3, 4'h0, 1, 2'b01, 4'h0, 9'h000));
        repeat (3) tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h3, 9'h02A));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h02A));
        tbl.push_back(mk(0, 0, 9'h105, 2'b00, 8'd0, 4'h0, 1, 2'b10, 4'h0, 9'h100));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'hC, 9'h105));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h02A));
        tbl.push_back(mk(0, 0, 9'h077, 2'b00, 8'd2, 4'h0, 1, 2'b01, 4'h0, 9'h02A));
        repeat (4) tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h2, 0, 2'b00, 4'h0, 9'h077));
        repeat (2) tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h3, 9'h077));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h077));
        tbl.push_back(mk(0, 0, 9'h133, 2'b00, 8'd2, 4'h0, 1, 2'b10, 4'h0, 9'h105));
        tbl.push_back(mk(0, 0, 9'h044, 2'b00, 8'd2, 4'h0, 1, 2'b01, 4'h0, 9'h077));
        repeat (2) tbl.push_back(mk(0, 0, 9'h055, 2'b00, 8'd2, 4'h0, 0, 2'b00, 4'h3, 9'h044));
        repeat (2) tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'hC, 9'h133));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h044));
        tbl.push_back(mk(0, 0, 9'h066, 2'b01, 8'd2, 4'h0, 0, 2'b00, 4'h0, 9'h044));
        tbl.push_back(mk(0, 0, 9'h099, 2'b00, 8'd5, 4'h0, 1, 2'b01, 4'h0, 9'h044));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h3, 9'h099));
        tbl.push_back(mk(1, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h099));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h000));
`else
        tbl.push_back(mk(0, 0, 9'h011, 2'b00, 8'd2, 4'h0, 1, 2'b01, 4'h3, 9'h011));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h3, 9'h011));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h011));
        tbl.push_back(mk(0, 0, 9'h105, 2'b00, 8'd0, 4'h0, 1, 2'b10, 4'hC, 9'h105));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h011));
        tbl.push_back(mk(0, 0, 9'h022, 2'b00, 8'd2, 4'h2, 1, 2'b01, 4'h0, 9'h011));
        repeat (2) tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h3, 9'h022));
        tbl.push_back(mk(0, 1, 9'h000, 2'b11, 8'd0, 4'h0, 0, 2'b00, 4'h0, 9'h022));
`endif
        for (int i = 0; i < tbl.size(); i++)
            apply_row(tbl[i], i);

        // Burst timing: flux 0, N=2, data 0x11, from pick cycle to last copy.
        nw = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b0; wr_full = '0; nda_empty = 2'b00; nda_dout = 9'd2;
            rd_dout = 9'h011;
            rd_empty = (i == 0) ? 1'b0 : 1'b1;
            #2;
            if (wr_write == 4'h3) begin
                nw++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("burst_writes", 0, 32'(nw), 32'd2);
`ifdef DDF_EXPAND_BYPASS_EN
        check("first_write", 0, 32'(first), 32'd0);
        check("burst_span", 0, 32'(last + 1), 32'd2);
`else
        check("first_write", 0, 32'(first), 32'd1);
        check("burst_span", 0, 32'(last + 1), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
